// File: rtl/fifo_pkg.sv
// Shared constants and types for the asynchronous FIFO and its read-side adapters.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH   = 32;
    localparam int unsigned RD_BUF_DEPTH = 2;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream, as seen by the read-side adapter.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH
);

    logic             read;
    logic             rempty;
    logic [WIDTH-1:0] rdata;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        output read,
        output m_valid,
        output m_data,
        input  rempty,
        input  rdata,
        input  m_ready
    );

    modport slave (
        input  read,
        input  m_valid,
        input  m_data,
        output rempty,
        output rdata,
        output m_ready
    );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry circular output buffer; head entry is registered storage driving the stream.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem_q [RD_BUF_DEPTH];
    logic             head_q;
    logic             tail_q;
    logic [1:0]       occ_q;

    // Storage is cleared on reset so the stream data reads as zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= push_data;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = mem_q[head_q];
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: converts the FIFO pop strobe interface into a valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rreset,
    fifo_rd_stream_if.master bus,
    output logic [CNT_W-1:0] words_out
);

    logic             inflight_q;
    logic [1:0]       occ;
    logic [1:0]       credit_used;
    logic             pop_out;
    logic             read;
    logic [WIDTH-1:0] head_data;
    logic [CNT_W-1:0] words_q;

    assign pop_out = bus.m_valid && bus.m_ready;

    // A pop is only issued if its word is guaranteed a free slot when it lands.
    always_comb begin
        credit_used = occ + {1'b0, inflight_q} - {1'b0, pop_out};
        read        = !rreset && !bus.rempty && (credit_used < 2'd2);
    end

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            inflight_q <= 1'b0;
            words_q    <= '0;
        end else begin
            inflight_q <= read;
            words_q    <= words_q + CNT_W'(pop_out);
        end
    end

    rd_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (rclk),
        .rst       (rreset),
        .push      (inflight_q),
        .push_data (bus.rdata),
        .pop       (pop_out),
        .head_data (head_data),
        .occ       (occ)
    );

    assign bus.read    = read;
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head_data;
    assign words_out   = words_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO model plus in-order scoreboard.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    logic rclk = 1'b0;
    logic rreset;
    always #5 rclk = ~rclk;

    fifo_rd_stream_if #(.WIDTH(FIFO_WIDTH)) bus ();
    fifo_rd_stream_if #(.WIDTH(FIFO_WIDTH)) bus_w ();
    logic [15:0] words_out;
    logic [3:0]  words_out_w;

    fifo_rd_stream #(.WIDTH(FIFO_WIDTH), .CNT_W(16)) dut (
        .rclk      (rclk),
        .rreset    (rreset),
        .bus       (bus),
        .words_out (words_out)
    );

    fifo_rd_stream #(.WIDTH(FIFO_WIDTH), .CNT_W(4)) dut_w (
        .rclk      (rclk),
        .rreset    (rreset),
        .bus       (bus_w),
        .words_out (words_out_w)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    fifo_word_t q[$];
    fifo_word_t exp_q[$];
    bit         mask_empty;
    logic       s_read, s_valid, s_empty, s_ready, s_deliv;
    fifo_word_t s_data;
    int         popped, delivered;

    // One read-clock cycle of the FIFO model; entered and left at the falling edge.
    task automatic tick();
        bit         pend;
        fifo_word_t pend_word;
        bus.rempty = (q.size() == 0) || mask_empty;
        #1;
        s_read  = bus.read;
        s_valid = bus.m_valid;
        s_data  = bus.m_data;
        s_empty = bus.rempty;
        s_ready = bus.m_ready;
        s_deliv = s_valid && s_ready;
        pend    = 1'b0;
        pend_word = '0;
        if (s_read && !s_empty) begin
            pend_word = q.pop_front();
            pend      = 1'b1;
            popped++;
        end
        if (s_deliv) delivered++;
        @(posedge rclk);
        #1;
        bus.rdata = pend ? pend_word : fifo_word_t'($urandom);
        @(negedge rclk);
    endtask

    task automatic do_reset();
        rreset = 1'b1;
        q.delete();
        exp_q.delete();
        popped = 0;
        delivered = 0;
        mask_empty = 1'b0;
        bus.m_ready = 1'b0;
        bus.rempty = 1'b1;
        repeat (2) @(negedge rclk);
        rreset = 1'b0;
    endtask

    task automatic load(input fifo_word_t w);
        q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        fifo_word_t want;
        @(negedge rclk);
        n_tests++;
        if (bus.read !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0 || words_out !== '0) begin
            n_fail++;
            $display("FAIL reset_init: read=%b valid=%b data=%h words=%0d want 0/0/0/0",
                     bus.read, bus.m_valid, bus.m_data, words_out);
        end
        rreset = 1'b0;
        for (int i = 0; i < 6; i++) load(fifo_word_t'(32'hA000 + i));
        bus.m_ready = 1'b1;
        repeat (3) begin
            tick();
            if (s_deliv) begin
                want = exp_q.pop_front();
                n_tests++;
                if (s_data !== want) begin
                    n_fail++;
                    $display("FAIL reset_pre_data: got %h want %h", s_data, want);
                end
            end
        end
        bus.m_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (words_out == 0 || !bus.m_valid) begin
            n_fail++;
            $display("FAIL reset_setup: words=%0d valid=%b want nonzero/1", words_out, bus.m_valid);
        end
        // Assert reset in the middle of the high phase, away from any edge.
        @(posedge rclk);
        #2;
        rreset = 1'b1;
        bus.rempty = 1'b0;
        #1;
        n_tests++;
        if (bus.read !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0 || words_out !== '0) begin
            n_fail++;
            $display("FAIL reset_async: read=%b valid=%b data=%h words=%0d want 0/0/0/0",
                     bus.read, bus.m_valid, bus.m_data, words_out);
        end
        repeat (3) begin
            @(negedge rclk);
            n_tests++;
            if (bus.read !== 1'b0 || bus.m_valid !== 1'b0 || words_out !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: read=%b valid=%b words=%0d want 0/0/0",
                         bus.read, bus.m_valid, words_out);
            end
        end
        rreset = 1'b0;
        #1;
        n_tests++;
        if (bus.read !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_read: got %b want 1", bus.read);
        end
    endtask

    task automatic test_single();
        int reads = 0, valids = 0, read_cyc = -1, valid_cyc = -1;
        do_reset();
        load(32'hDEADBEEF);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_read) begin reads++; read_cyc = c; end
            if (s_valid) begin
                valids++;
                valid_cyc = c;
                n_tests++;
                if (s_data !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL single_data: got %h want deadbeef", s_data);
                end
            end
        end
        n_tests++;
        if (reads != 1) begin
            n_fail++;
            $display("FAIL single_reads: got %0d want 1", reads);
        end
        n_tests++;
        if (valids != 1 || valid_cyc != read_cyc + 2) begin
            n_fail++;
            $display("FAIL single_latency: valids=%0d at %0d want 1 at %0d",
                     valids, valid_cyc, read_cyc + 2);
        end
        n_tests++;
        if (words_out !== 16'd1) begin
            n_fail++;
            $display("FAIL single_words: got %0d want 1", words_out);
        end
    endtask

    task automatic test_backpressure();
        int         reads = 0;
        fifo_word_t want;
        do_reset();
        for (int i = 1; i <= 5; i++) load(fifo_word_t'(i));
        bus.m_ready = 1'b0;
        repeat (8) begin
            tick();
            if (s_read) reads++;
        end
        n_tests++;
        if (reads != 2) begin
            n_fail++;
            $display("FAIL bp_reads: got %0d want 2", reads);
        end
        n_tests++;
        if (s_valid !== 1'b1 || s_data !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h want 1/1", s_valid, s_data);
        end
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20 && delivered < 5; c++) begin
            tick();
            if (s_deliv) begin
                want = exp_q.pop_front();
                n_tests++;
                if (s_data !== want) begin
                    n_fail++;
                    $display("FAIL bp_order: got %h want %h", s_data, want);
                end
            end
        end
        n_tests++;
        if (delivered != 5 || words_out !== 16'd5) begin
            n_fail++;
            $display("FAIL bp_count: delivered=%0d words=%0d want 5/5", delivered, words_out);
        end
    endtask

    task automatic test_stream();
        int         first = -1, run = 0, bad_reads = 0, data_err = 0;
        bit         gap = 1'b0;
        fifo_word_t want;
        do_reset();
        for (int i = 0; i < 100; i++) load(fifo_word_t'($urandom));
        bus.m_ready = 1'b1;
        for (int c = 0; c < 110; c++) begin
            tick();
            if (s_read && s_empty) bad_reads++;
            if (s_valid) begin
                if (first < 0) first = c;
                if (!gap) run++;
                want = exp_q.pop_front();
                if (s_data !== want) data_err++;
            end else if (first >= 0) begin
                gap = 1'b1;
            end
        end
        n_tests++;
        if (first != 2 || run != 100) begin
            n_fail++;
            $display("FAIL stream_run: first=%0d run=%0d want 2/100", first, run);
        end
        n_tests++;
        if (data_err != 0 || bad_reads != 0) begin
            n_fail++;
            $display("FAIL stream_data: data_err=%0d bad_reads=%0d want 0/0", data_err, bad_reads);
        end
        n_tests++;
        if (words_out !== 16'd100) begin
            n_fail++;
            $display("FAIL stream_words: got %0d want 100", words_out);
        end
    endtask

    task automatic test_random();
        fifo_word_t want, prev_data = '0;
        bit         prev_stall = 1'b0;
        int         cyc = 0;
        do_reset();
        for (int i = 0; i < 1000; i++) load(fifo_word_t'($urandom));
        while (delivered < 1000 && cyc < 20000) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            mask_empty  = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
            n_tests++;
            if (s_read && s_empty) begin
                n_fail++;
                $display("FAIL rand_read_empty: cycle %0d read=1 while rempty=1", cyc);
            end
            n_tests++;
            if (popped - delivered > 2) begin
                n_fail++;
                $display("FAIL rand_occupancy: outstanding=%0d want <=2", popped - delivered);
            end
            if (prev_stall) begin
                n_tests++;
                if (s_valid !== 1'b1 || s_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL rand_stable: valid=%b data=%h want 1/%h", s_valid, s_data,
                             prev_data);
                end
            end
            if (s_deliv) begin
                want = exp_q.pop_front();
                n_tests++;
                if (s_data !== want) begin
                    n_fail++;
                    $display("FAIL rand_order: word %0d got %h want %h", delivered, s_data, want);
                end
            end
            prev_stall = s_valid && !s_ready;
            prev_data  = s_data;
        end
        n_tests++;
        if (delivered != 1000 || words_out !== 16'd1000) begin
            n_fail++;
            $display("FAIL rand_count: delivered=%0d words=%0d want 1000/1000", delivered, words_out);
        end
    endtask

    task automatic test_wrap();
        int         sent = 0, got = 0;
        bit         pend;
        fifo_word_t pend_word, want;
        do_reset();
        bus_w.m_ready = 1'b1;
        for (int c = 0; c < 60 && got < 19; c++) begin
            bus_w.rempty = (sent >= 19);
            #1;
            pend = 1'b0;
            pend_word = '0;
            if (bus_w.read && !bus_w.rempty) begin
                pend = 1'b1;
                pend_word = fifo_word_t'(32'h100 + sent);
                sent++;
            end
            if (bus_w.m_valid && bus_w.m_ready) begin
                want = fifo_word_t'(32'h100 + got);
                n_tests++;
                if (bus_w.m_data !== want) begin
                    n_fail++;
                    $display("FAIL wrap_order: got %h want %h", bus_w.m_data, want);
                end
                got++;
            end
            @(posedge rclk);
            #1;
            bus_w.rdata = pend ? pend_word : fifo_word_t'($urandom);
            @(negedge rclk);
        end
        bus_w.rempty = 1'b1;
        n_tests++;
        if (got != 19 || words_out_w !== 4'd3) begin
            n_fail++;
            $display("FAIL wrap_words: delivered=%0d words=%0d want 19/3", got, words_out_w);
        end
    endtask

    initial begin
        rreset = 1'b1;
        mask_empty = 1'b0;
        popped = 0;
        delivered = 0;
        bus.rempty = 1'b1;
        bus.m_ready = 1'b0;
        bus.rdata = '0;
        bus_w.rempty = 1'b1;
        bus_w.m_ready = 1'b1;
        bus_w.rdata = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
